// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter sharing the ALU operand path between requesters A and B.
// Latency: operand appears on out_data 1 cycle after its valid/ready transfer.
// Backpressure: out_valid/out_data held until out_ready; then HOLD_CYCLES guard cycles before the next grant.
module alu_operand_arbiter #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CW          = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Counter load value: the HOLD state exits when the counter reads zero,
    // so loading HOLD_CYCLES-1 yields exactly HOLD_CYCLES guard cycles.
    localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_grant_q;
    logic          winner;
    logic          take;
    logic          out_fire;

    // Winner selection: a lone requester wins; on contention the one not granted last time wins.
    always_comb begin
        winner = 1'b0;
        if (a_valid && b_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = b_valid;
        end
    end

    // A grant is only offered from IDLE, so at most one ready is ever high.
    assign take     = (state_q == IDLE) && (a_valid || b_valid);
    assign a_ready  = take && !winner;
    assign b_ready  = take && winner;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state_q != IDLE);

    // State and guard counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> OUT on transfer, OUT -> HOLD/IDLE on handshake, HOLD counts down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_fire) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output datapath: capture the winner on the transfer edge, drop valid on the ALU handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_src      <= 1'b0;
            sel          <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (take) begin
            out_valid    <= 1'b1;
            out_data     <= winner ? b_data : a_data;
            out_src      <= winner;
            sel          <= winner;
            last_grant_q <= winner;
        end else if (out_fire) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Self-checking bench for alu_operand_arbiter: two instances (guard 2 and guard 0)
// share stimulus; a cycle-timeline reference model predicts every output each cycle.
module tb_alu_operand_arbiter;

    localparam int H_A = 2;
    localparam int H_B = 0;
    localparam int CWP = 4;

    if (H_A > 15 || H_B > 15 || (1 << CWP) <= H_A || (1 << CWP) <= H_B) begin : g_cfg_bad
        initial $fatal(1, "FAIL config: HOLD_CYCLES out of range for CW");
    end

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [3:0] a_data;
    logic       b_valid;
    logic [3:0] b_data;
    logic       out_ready;
    logic [1:0] ar, br, sl, ov, os, bz;
    logic [3:0] od0, od1;

    int errors = 0;
    int checks = 0;

    alu_operand_arbiter #(.WIDTH(4), .HOLD_CYCLES(H_A), .CW(CWP)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(ar[0]),
        .b_valid(b_valid), .b_data(b_data), .b_ready(br[0]),
        .sel(sl[0]), .out_valid(ov[0]), .out_data(od0), .out_src(os[0]),
        .out_ready(out_ready), .busy(bz[0])
    );

    alu_operand_arbiter #(.WIDTH(4), .HOLD_CYCLES(H_B), .CW(CWP)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(ar[1]),
        .b_valid(b_valid), .b_data(b_data), .b_ready(br[1]),
        .sel(sl[1]), .out_valid(ov[1]), .out_data(od1), .out_src(os[1]),
        .out_ready(out_ready), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an operand is either pending toward the ALU, or the
    // block is free to accept from cycle m_free onward (guard time after handshake).
    int         cyc;
    int         m_h [2] = '{H_A, H_B};
    bit         m_pv [2];
    logic [3:0] m_od [2];
    bit         m_sel [2];
    bit         m_last [2];
    int         m_free [2];

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_pv[i] = 0; m_od[i] = 4'h0; m_sel[i] = 0; m_last[i] = 1; m_free[i] = 0;
        end
    endtask

    task automatic check_inst(input int i, input logic g_ar, input logic g_br, input logic g_sel,
                              input logic g_ov, input logic [3:0] g_od, input logic g_os,
                              input logic g_bz);
        bit can, w, ar_e, br_e, bz_e;
        can  = !m_pv[i] && (cyc >= m_free[i]);
        w    = (a_valid && b_valid) ? !m_last[i] : b_valid;
        ar_e = can && a_valid && !w;
        br_e = can && b_valid && w;
        bz_e = m_pv[i] || (cyc < m_free[i]);
        chk($sformatf("a_ready[%0d]", i), 4'(g_ar), 4'(ar_e));
        chk($sformatf("b_ready[%0d]", i), 4'(g_br), 4'(br_e));
        chk($sformatf("out_valid[%0d]", i), 4'(g_ov), 4'(m_pv[i]));
        chk($sformatf("out_data[%0d]", i), g_od, m_od[i]);
        chk($sformatf("out_src[%0d]", i), 4'(g_os), 4'(m_sel[i]));
        chk($sformatf("sel[%0d]", i), 4'(g_sel), 4'(m_sel[i]));
        chk($sformatf("busy[%0d]", i), 4'(g_bz), 4'(bz_e));
        if (m_pv[i]) begin
            if (out_ready) begin
                m_pv[i]   = 0;
                m_free[i] = cyc + 1 + m_h[i];
            end
        end else if (ar_e || br_e) begin
            m_pv[i]   = 1;
            m_od[i]   = w ? b_data : a_data;
            m_sel[i]  = w;
            m_last[i] = w;
        end
    endtask

    // One clock: check both instances against the model, then advance to the next negedge.
    task automatic step();
        #1;
        check_inst(0, ar[0], br[0], sl[0], ov[0], od0, os[0], bz[0]);
        check_inst(1, ar[1], br[1], sl[1], ov[1], od1, os[1], bz[1]);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear without a clock edge; release on a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_out_valid[%0d]", i), 4'(ov[i]), 4'h0);
            chk($sformatf("rst_sel[%0d]", i), 4'(sl[i]), 4'h0);
            chk($sformatf("rst_out_src[%0d]", i), 4'(os[i]), 4'h0);
            chk($sformatf("rst_busy[%0d]", i), 4'(bz[i]), 4'h0);
        end
        chk("rst_out_data[0]", od0, 4'h0);
        chk("rst_out_data[1]", od1, 4'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] got_d [$];
        logic       got_s [$];
        int         got_c [$];
        bit         found;

        rst_n = 1'b1; a_valid = 0; a_data = 0; b_valid = 0; b_data = 0; out_ready = 0;
        model_reset();
        #2;

        // Single A request with guard of 2.
        do_reset();
        a_valid = 1; a_data = 4'h5; out_ready = 1;
        #1 chk("t1_a_ready_c0", 4'(ar[0]), 4'h1);
        step();
        #1 chk("t1_out_valid_c1", 4'(ov[0]), 4'h1);
        chk("t1_out_data_c1", od0, 4'h5);
        chk("t1_out_src_c1", 4'(os[0]), 4'h0);
        chk("t1_sel_c1", 4'(sl[0]), 4'h0);
        step();
        #1 chk("t1_out_valid_c2", 4'(ov[0]), 4'h0);
        chk("t1_busy_c2", 4'(bz[0]), 4'h1);
        step();
        #1 chk("t1_a_ready_c3", 4'(ar[0]), 4'h0);
        chk("t1_busy_c3", 4'(bz[0]), 4'h1);
        step();
        #1 chk("t1_a_ready_c4", 4'(ar[0]), 4'h1);
        step();

        // Contention: alternating grants spaced 4 cycles apart.
        do_reset();
        a_valid = 1; a_data = 4'h3; b_valid = 1; b_data = 4'hC; out_ready = 1;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (ov[0]) begin
                got_d.push_back(od0); got_s.push_back(sl[0]); got_c.push_back(k);
            end
            step();
        end
        chk("rr_count", 4'(got_d.size()), 4'd4);
        for (int j = 0; j < 4 && j < got_d.size(); j++) begin
            chk($sformatf("rr_data%0d", j), got_d[j], (j % 2 == 0) ? 4'h3 : 4'hC);
            chk($sformatf("rr_sel%0d", j), 4'(got_s[j]), 4'(j % 2));
            chk($sformatf("rr_cycle%0d", j), 4'(got_c[j]), 4'(1 + 4 * j));
        end

        // Backpressure after a B grant.
        do_reset();
        a_valid = 0; b_valid = 1; b_data = 4'hA; out_ready = 1;
        #1 chk("bp_b_ready", 4'(br[0]), 4'h1);
        step();
        a_valid = 1; out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("bp_out_valid%0d", k), 4'(ov[0]), 4'h1);
            chk($sformatf("bp_out_data%0d", k), od0, 4'hA);
            chk($sformatf("bp_a_ready%0d", k), 4'(ar[0]), 4'h0);
            chk($sformatf("bp_b_ready%0d", k), 4'(br[0]), 4'h0);
            step();
        end
        out_ready = 1;
        step();
        #1 chk("bp_done_out_valid", 4'(ov[0]), 4'h0);
        step();

        // Guard 0, only B valid: accepted every other cycle.
        do_reset();
        a_valid = 0; b_valid = 1; b_data = 4'h6; out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("h0_b_ready%0d", k), 4'(br[1]), 4'((k % 2) == 0));
            if (k % 2 == 1) chk($sformatf("h0_out_src%0d", k), 4'(os[1]), 4'h1);
            step();
        end

        // Reset pulse while in OUT discards the operand; A has priority afterwards.
        do_reset();
        a_valid = 1; a_data = 4'h7; b_valid = 0; out_ready = 0;
        step();
        #1 chk("ro_out_data_before", od0, 4'h7);
        #1 do_reset();
        a_valid = 1; b_valid = 1; b_data = 4'h2; out_ready = 1;
        #1 chk("ro_a_first", 4'(ar[0]), 4'h1);
        step();
        step();

        // Data change while waiting: value on the transfer edge is captured.
        do_reset();
        a_valid = 0; b_valid = 1; b_data = 4'h2; out_ready = 0;
        step();
        a_valid = 1; a_data = 4'h1;
        step();
        a_data = 4'h9; b_valid = 0; out_ready = 1;
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            #1 if (ov[0] && !os[0]) found = 1;
        end
        chk("dc_found", 4'(found), 4'h1);
        chk("dc_out_data", od0, 4'h9);
        step();

        // Randomized traffic with occasional asynchronous reset.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 do_reset();
            end
            a_valid   = 1'($urandom_range(0, 1));
            b_valid   = 1'($urandom_range(0, 1));
            a_data    = 4'($urandom);
            b_data    = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
